// File: rtl/decod_stream.sv
// Registered SEL_W-to-2**SEL_W decoder (one-hot or thermometer) with a
// valid/ready handshake on each side. A one-word skid buffer allows full throughput.
module decod_stream #(
  parameter int SEL_W      = 4,
  parameter bit INVERT_SEL = 1'b1,
  localparam int OUT_W     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_en,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_dec
);

  logic [SEL_W-1:0] idx;
  logic [OUT_W-1:0] dec_word;
  logic [OUT_W-1:0] skid_word;
  logic             skid_full;
  logic             in_xfer;
  logic             out_free;

  assign idx = INVERT_SEL ? ~in_sel : in_sel;

  // Each output bit compares its own position against the index.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
      localparam logic [SEL_W-1:0] pos = SEL_W'(gi);
      assign dec_word[gi] = in_en & (in_mode ? (pos <= idx) : (pos == idx));
    end
  endgenerate

  // in_ready depends only on rst and registered state, never on out_ready.
  assign in_ready = ~skid_full & ~rst;
  assign in_xfer  = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_dec   <= '0;
      skid_full <= 1'b0;
      skid_word <= '0;
    end else if (out_free) begin
      if (skid_full) begin
        out_dec   <= skid_word;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_xfer) begin
        out_dec   <= dec_word;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_word <= dec_word;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decod_stream.sv
// Bench for decod_stream: two instances (inverted and plain index) share the stimulus
// and are checked every cycle against a queue model, plus fixed expected words.
module tb_decod_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_sel;
  logic        in_en;
  logic        in_mode;
  logic        out_ready;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [15:0] out_dec_a, out_dec_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decod_stream #(.SEL_W(4), .INVERT_SEL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sel(in_sel), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_dec(out_dec_a)
  );

  decod_stream #(.SEL_W(4), .INVERT_SEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sel(in_sel), .in_en(in_en), .in_mode(in_mode),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_dec(out_dec_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_dec(input logic [3:0] sel, input bit inv,
                                            input bit en, input bit mode);
    int idx;
    idx = inv ? 15 - int'(sel) : int'(sel);
    if (!en) return 16'h0000;
    if (mode) return 16'((32'd1 << (idx + 1)) - 1);
    return 16'(32'd1 << idx);
  endfunction

  // The block holds at most two words; the head of the queue is what is on out_dec.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit model_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      model_on <= 1;
    end else if (model_on) begin
      bit can_take;
      can_take = qa.size() < 2;
      if (qa.size() > 0 && out_ready) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (in_valid && can_take) begin
        qa.push_back(model_dec(in_sel, 1, in_en, in_mode));
        qb.push_back(model_dec(in_sel, 0, in_en, in_mode));
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("in_ready_a", 32'(in_ready_a), 32'(!rst && qa.size() < 2));
      chk("in_ready_b", 32'(in_ready_b), 32'(!rst && qb.size() < 2));
      chk("out_valid_a", 32'(out_valid_a), 32'(qa.size() > 0));
      chk("out_valid_b", 32'(out_valid_b), 32'(qb.size() > 0));
      if (qa.size() > 0) begin
        chk("model_dec_a", 32'(out_dec_a), 32'(qa[0]));
        chk("model_dec_b", 32'(out_dec_b), 32'(qb[0]));
      end
    end
  end

  // Captures delivered words of the inverted instance for literal sequence checks.
  logic [15:0] cap[$];
  bit ready_low;
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready) cap.push_back(out_dec_a);
    if (!rst && !in_ready_a) ready_low = 1;
  end

  logic [3:0] st_sel[64];
  bit         st_en[64];
  bit         st_mode[64];

  // Called aligned 1 time unit after a rising edge.
  task automatic beat(input logic [3:0] sel, input bit en, input bit mode,
                      input logic [15:0] exp_a, input logic [15:0] exp_b, input string name);
    in_valid = 1; in_sel = sel; in_en = en; in_mode = mode; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid_a), 32'd1);
    chk({name, "_a"}, 32'(out_dec_a), 32'(exp_a));
    chk({name, "_b"}, 32'(out_dec_b), 32'(exp_b));
    $display("beat %s sel=%h en=%0d mode=%0d -> a=%h b=%h", name, sel, en, mode, out_dec_a, out_dec_b);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n, input int stall, output int cycles);
    int i = 0;
    int c = 0;
    bit acc;
    while (i < n && c < 400) begin
      in_valid = 1; in_sel = st_sel[i]; in_en = st_en[i]; in_mode = st_mode[i];
      out_ready = (c >= stall);
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    in_valid = 0;
    out_ready = 1;
    if (i < n) chk("stream_timeout", 32'(i), 32'(n));
    for (int k = 0; k < 20 && qa.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    chk("stream_drained", 32'(qa.size()), 32'd0);
    cycles = c;
  endtask

  initial begin
    int cyc;
    rst = 1; in_valid = 1; in_sel = 4'h0; in_en = 1; in_mode = 0; out_ready = 1;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready_a), 32'd0);
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_out_dec", 32'(out_dec_a), 32'd0);
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready_a), 32'd1);
    $display("reset done in_ready=%0d", in_ready_a);
    @(posedge clk); #1;

    beat(4'hF, 1, 0, 16'h0001, 16'h8000, "oh_sel_f");
    beat(4'h0, 1, 0, 16'h8000, 16'h0001, "oh_sel_0");
    beat(4'h5, 0, 0, 16'h0000, 16'h0000, "disabled");
    beat(4'h3, 1, 1, 16'h1FFF, 16'h000F, "th_sel_3");
    beat(4'hF, 1, 1, 16'h0001, 16'hFFFF, "th_sel_f");
    beat(4'h0, 1, 1, 16'hFFFF, 16'h0001, "th_sel_0");

    // Backpressure: out_ready low for the first 3 cycles of the stream.
    for (int k = 0; k < 4; k++) begin
      st_sel[k] = 4'(k + 1); st_en[k] = 1; st_mode[k] = 0;
    end
    cap.delete(); ready_low = 0;
    run_stream(4, 3, cyc);
    chk("bp_count", 32'(cap.size()), 32'd4);
    chk("bp_ready_low", 32'(ready_low), 32'd1);
    if (cap.size() == 4) begin
      chk("bp_word0", 32'(cap[0]), 32'h4000);
      chk("bp_word1", 32'(cap[1]), 32'h2000);
      chk("bp_word2", 32'(cap[2]), 32'h1000);
      chk("bp_word3", 32'(cap[3]), 32'h0800);
    end
    $display("backpressure stream: %0d words in %0d cycles", cap.size(), cyc);

    // Full rate random stream.
    for (int k = 0; k < 64; k++) begin
      st_sel[k] = 4'($urandom_range(0, 15));
      st_en[k] = ($urandom_range(0, 7) != 0);
      st_mode[k] = 1'($urandom_range(0, 1));
    end
    cap.delete();
    run_stream(64, 0, cyc);
    chk("full_rate_cycles", 32'(cyc), 32'd64);
    chk("full_rate_count", 32'(cap.size()), 32'd64);
    $display("full rate stream: %0d words in %0d cycles", cap.size(), cyc);

    // Reset while stalled with the skid full.
    out_ready = 0; in_valid = 1; in_en = 1; in_mode = 0; in_sel = 4'h7;
    @(posedge clk); #1;
    in_sel = 4'h8;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready_a), 32'd0);
    chk("stall_out_valid", 32'(out_valid_a), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    beat(4'h9, 1, 0, 16'h0040, 16'h0200, "post_rst_beat");
    @(negedge clk);
    chk("no_stale_word", 32'(out_valid_a), 32'd0);
    $display("reset mid-stall: out_valid=%0d after first beat", out_valid_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
